// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, per-length schedule sizes, GF(2^8) xtime.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int RK_W   = 128;
    localparam int NUM_RK = 15;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_t;

    // Key length in 32-bit words
    function automatic logic [3:0] nk_of(input key_len_t kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    // Number of cipher rounds
    function automatic logic [3:0] nr_of(input key_len_t kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Total expanded words, 4*(NR+1)
    function automatic logic [5:0] nw_of(input key_len_t kl);
        case (kl)
            KL_128:  return 6'd44;
            KL_192:  return 6'd52;
            default: return 6'd60;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) multiplicative inverse followed by the affine transform.
// Latency: combinational.
// Backpressure: none; pure function of the input byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xa;
        logic [7:0] yb;
        p  = 8'h00;
        xa = x;
        yb = y;
        for (int k = 0; k < 8; k++) begin
            if (yb[0]) p = p ^ xa;
            xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
            yb = {1'b0, yb[7:1]};
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Byte substitution
    always_comb begin
        s = affine(ginv(a));
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES key expansion (128/192/256) through one SubWord unit, with indexed round-key readout.
// Latency: ready 41/47/53 cycles after start; round-key read returns 1 cycle after rk_req.
// Backpressure: none; start ignored while busy, reads outside DONE are dropped.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         ready,
    output logic [3:0]   nr,
    output logic         err,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_data
);

    state_t       state;
    state_t       state_nxt;
    logic [255:0] key_q;
    logic [3:0]   nk_q;
    logic [5:0]   w_last_q;
    logic [5:0]   i_q;
    logic [2:0]   j_q;
    logic [7:0]   rcon_q;
    logic [31:0]  win [0:7];
    logic [31:0]  kw  [0:7];
    logic [RK_W-1:0] rk_mem [0:NUM_RK-1];

    logic         idle_or_done;
    logic         start_ok;
    logic         start_bad;
    logic [2:0]   back_idx;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp;
    logic [31:0]  w_new;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok     = idle_or_done && start && (key_len != 2'b11);
    assign start_bad    = idle_or_done && start && (key_len == 2'b11);
    assign busy         = (state == ST_LOAD) || (state == ST_EXPAND);
    assign ready        = (state == ST_DONE);

    // Window holds w[i-8..i-1] with w[i-1] in slot 7, so w[i-NK] sits in slot 8-NK
    assign back_idx = 3'(4'd8 - nk_q);
    assign w_prev   = win[7];
    assign w_back   = win[back_idx];
    assign sub_in   = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .s (sub_out[8*b +: 8])
        );
    end

    // Split the latched key into words, word 0 in the top bits
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            kw[k] = key_q[255 - 32*k -: 32];
        end
    end

    // Schedule core: RotWord/SubWord/Rcon on word boundaries, extra SubWord mid-block for 256-bit keys
    always_comb begin
        temp = w_prev;
        if (j_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if ((nk_q == 4'd8) && (j_q == 3'd4)) begin
            temp = sub_out;
        end
        w_new = w_back ^ temp;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_EXPAND;
            ST_EXPAND: if (i_q == w_last_q) state_nxt = ST_DONE;
            ST_DONE:   if (start_ok) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Expansion datapath and key storage; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (start_ok) begin
            key_q    <= key_in;
            nk_q     <= nk_of(key_len_t'(key_len));
            w_last_q <= nw_of(key_len_t'(key_len)) - 6'd1;
        end
        if (state == ST_LOAD) begin
            // Slot m gets key word m+NK-8 (mod 8); slots below 8-NK are never read
            for (int m = 0; m < 8; m++) begin
                win[m] <= kw[3'(4'(m) + nk_q)];
            end
            rk_mem[0] <= key_q[255:128];
            rk_mem[1] <= key_q[127:0];
            i_q       <= {2'b00, nk_q};
            j_q       <= 3'd0;
            rcon_q    <= 8'h01;
        end
        if (state == ST_EXPAND) begin
            for (int m = 0; m < 7; m++) begin
                win[m] <= win[m+1];
            end
            win[7] <= w_new;
            rk_mem[i_q[5:2]][{~i_q[1:0], 5'd0} +: 32] <= w_new;
            i_q <= i_q + 6'd1;
            j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
    end

    // Registered status, error pulse and round-key read port
    always_ff @(posedge clk) begin
        if (rst) begin
            nr       <= 4'd0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
        end else begin
            err      <= start_bad;
            rk_valid <= 1'b0;
            if (start_ok) nr <= nr_of(key_len_t'(key_len));
            if ((state == ST_DONE) && rk_req) begin
                rk_valid <= 1'b1;
                if (rk_idx <= nr) begin
                    rk_data <= rk_mem[rk_idx];
                end else begin
                    rk_data <= '0;
                    err     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         ready;
    logic [3:0]   nr;
    logic         err;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] exp128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .ready    (ready),
        .nr       (nr),
        .err      (err),
        .rk_req   (rk_req),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_data  (rk_data)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clk);
        start = 1'b1; key_len = kl; key_in = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after the start edge until ready; optionally pulse start at cycle inj
    task automatic wait_ready(input int inj, output int n, output logic both,
                              output logic errseen, output logic busy1);
        n = 0; both = 1'b0; errseen = 1'b0; busy1 = 1'b0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (busy && ready) both = 1'b1;
            if (err) errseen = 1'b1;
            if (n == 1) busy1 = busy;
            if (n == inj) begin
                start = 1'b1; key_len = 2'b10; key_in = K256;
            end else begin
                start = 1'b0;
            end
            if (ready) break;
        end
        start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, output logic v, output logic [127:0] d, output logic e);
        @(negedge clk);
        rk_req = 1'b1; rk_idx = idx;
        @(posedge clk); #1;
        rk_req = 1'b0;
        v = rk_valid; d = rk_data; e = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
        tests++; if (nr !== 4'd0) begin fails++; $display("FAIL reset_nr got %0d exp 0", nr); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        tests++; if (rk_valid !== 1'b0) begin fails++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
        tests++; if (rk_data !== 128'h0) begin fails++; $display("FAIL reset_rk_data got %h exp 0", rk_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_illegal_idle();
        do_start(2'b11, K128);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL idle_bad_err got %b exp 1", err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_bad_busy got %b exp 0", busy); end
        @(posedge clk); #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL idle_bad_err_pulse got %b exp 0", err); end
        tests++; if ({busy, ready} !== 2'b00) begin fails++; $display("FAIL idle_bad_state got %b exp 00", {busy, ready}); end
    endtask

    task automatic test_aes128();
        int n; logic both, es, b1, v, e; logic [127:0] d;
        do_start(2'b00, K128);
        wait_ready(0, n, both, es, b1);
        tests++; if (n !== 41) begin fails++; $display("FAIL aes128_latency got %0d exp 41", n); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL aes128_busy_ready_overlap got %b exp 0", both); end
        tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL aes128_busy_first got %b exp 1", b1); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL aes128_busy_done got %b exp 0", busy); end
        tests++; if (nr !== 4'd10) begin fails++; $display("FAIL aes128_nr got %0d exp 10", nr); end
        rd(4'd0, v, d, e);
        tests++; if ({v, d} !== {1'b1, exp128[0]}) begin fails++; $display("FAIL aes128_rk0 got %b %h exp 1 %h", v, d, exp128[0]); end
        rd(4'd1, v, d, e);
        tests++; if ({v, d} !== {1'b1, exp128[1]}) begin fails++; $display("FAIL aes128_rk1 got %b %h exp 1 %h", v, d, exp128[1]); end
        rd(4'd10, v, d, e);
        tests++; if ({v, d, e} !== {1'b1, exp128[10], 1'b0}) begin fails++; $display("FAIL aes128_rk10 got %b %h %b exp 1 %h 0", v, d, e, exp128[10]); end
    endtask

    task automatic test_oob_read();
        logic v, e; logic [127:0] d;
        rd(4'd11, v, d, e);
        tests++; if ({v, e} !== 2'b11) begin fails++; $display("FAIL oob_valid_err got %b exp 11", {v, e}); end
        tests++; if (d !== 128'h0) begin fails++; $display("FAIL oob_data got %h exp 0", d); end
        @(posedge clk); #1;
        tests++; if ({rk_valid, err} !== 2'b00) begin fails++; $display("FAIL oob_pulse got %b exp 00", {rk_valid, err}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rk_req = 1'b1; rk_idx = 4'd0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({rk_valid, rk_data} !== {1'b1, exp128[k]}) begin
                fails++; $display("FAIL b2b_rk%0d got %b %h exp 1 %h", k, rk_valid, rk_data, exp128[k]);
            end
            if (k < 10) rk_idx = 4'(k + 1);
            else        rk_req = 1'b0;
        end
        @(posedge clk); #1;
        tests++; if (rk_valid !== 1'b0) begin fails++; $display("FAIL b2b_tail got %b exp 0", rk_valid); end
    endtask

    task automatic test_illegal_done();
        logic v, e; logic [127:0] d;
        do_start(2'b11, K256);
        tests++; if ({err, ready, busy} !== 3'b110) begin fails++; $display("FAIL done_bad got %b exp 110", {err, ready, busy}); end
        tests++; if (nr !== 4'd10) begin fails++; $display("FAIL done_bad_nr got %0d exp 10", nr); end
        rd(4'd10, v, d, e);
        tests++; if ({v, d} !== {1'b1, exp128[10]}) begin fails++; $display("FAIL done_bad_keep got %b %h exp 1 %h", v, d, exp128[10]); end
    endtask

    task automatic test_start_during_expand();
        int n; logic both, es, b1, v, e; logic [127:0] d;
        do_start(2'b00, K128);
        wait_ready(10, n, both, es, b1);
        tests++; if (n !== 41) begin fails++; $display("FAIL midstart_latency got %0d exp 41", n); end
        tests++; if (es !== 1'b0) begin fails++; $display("FAIL midstart_err got %b exp 0", es); end
        tests++; if (nr !== 4'd10) begin fails++; $display("FAIL midstart_nr got %0d exp 10", nr); end
        rd(4'd10, v, d, e);
        tests++; if ({v, d} !== {1'b1, exp128[10]}) begin fails++; $display("FAIL midstart_rk10 got %b %h exp 1 %h", v, d, exp128[10]); end
    endtask

    task automatic test_aes192();
        int n; logic both, es, b1, v, e; logic [127:0] d;
        do_start(2'b01, K192);
        wait_ready(0, n, both, es, b1);
        tests++; if (n !== 47) begin fails++; $display("FAIL aes192_latency got %0d exp 47", n); end
        tests++; if (nr !== 4'd12) begin fails++; $display("FAIL aes192_nr got %0d exp 12", nr); end
        rd(4'd12, v, d, e);
        tests++; if ({v, d} !== {1'b1, 128'he98ba06f448c773c8ecc720401002202}) begin fails++; $display("FAIL aes192_rk12 got %b %h exp 1 e98ba06f448c773c8ecc720401002202", v, d); end
    endtask

    task automatic test_aes256();
        int n; logic both, es, b1, v, e; logic [127:0] d;
        do_start(2'b10, K256);
        wait_ready(0, n, both, es, b1);
        tests++; if (n !== 53) begin fails++; $display("FAIL aes256_latency got %0d exp 53", n); end
        tests++; if (nr !== 4'd14) begin fails++; $display("FAIL aes256_nr got %0d exp 14", nr); end
        rd(4'd14, v, d, e);
        tests++; if ({v, d} !== {1'b1, 128'hfe4890d1e6188d0b046df344706c631e}) begin fails++; $display("FAIL aes256_rk14 got %b %h exp 1 fe4890d1e6188d0b046df344706c631e", v, d); end
    endtask

    task automatic test_rst_mid_expand();
        int n; logic both, es, b1, v, e; logic [127:0] d;
        do_start(2'b00, K128);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if ({busy, ready} !== 2'b00) begin fails++; $display("FAIL rst_mid_state got %b exp 00", {busy, ready}); end
        @(negedge clk);
        rst = 1'b0;
        rd(4'd10, v, d, e);
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL rst_mid_read_ignored got %b exp 0", v); end
        do_start(2'b00, K128);
        wait_ready(0, n, both, es, b1);
        tests++; if (n !== 41) begin fails++; $display("FAIL rst_restart_latency got %0d exp 41", n); end
        rd(4'd10, v, d, e);
        tests++; if ({v, d} !== {1'b1, exp128[10]}) begin fails++; $display("FAIL rst_restart_rk10 got %b %h exp 1 %h", v, d, exp128[10]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0;
        rk_req = 1'b0; rk_idx = 4'd0;
        test_reset();
        test_illegal_idle();
        test_aes128();
        test_oob_read();
        test_back_to_back();
        test_illegal_done();
        test_start_during_expand();
        test_aes192();
        test_aes256();
        test_rst_mid_expand();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequential AES key-schedule controller: takes a 128/192/256-bit cipher key, expands it one 32-bit word per cycle through a single SubWord unit, and holds all round keys for the cipher round engine. The engine reads round keys by index over a registered request/valid port. Replaces the fully unrolled, combinational key expansion. Runtime-selectable key length; one sbox bank instead of ~40.

## Interface
Parameters:
- none; key length is a runtime input.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse: latch key_len and key_in, begin expansion
- key_len  in  2  00=AES-128 (NK=4, NR=10), 01=AES-192 (NK=6, NR=12), 10=AES-256 (NK=8, NR=14), 11=illegal
- key_in  in  256  key, byte 0 at [255:248]; only the upper NK*32 bits are used
- busy  out  1  expansion in progress (LOAD or EXPAND)
- ready  out  1  all round keys valid
- nr  out  4  round count of the loaded key (10/12/14); 0 until first successful load
- err  out  1  one-cycle pulse: illegal key_len on start, or out-of-range rk_idx
- rk_req  in  1  round-key read request
- rk_idx  in  4  round-key index 0..NR
- rk_valid  out  1  read-data strobe, one cycle
- rk_data  out  128  round key, {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]

## Operation
- States: IDLE, LOAD, EXPAND, DONE.
- IDLE: start && key_len!=11 -> LOAD; latch key_in, key_len, and NK/NR/W (W=4*(NR+1) = 44/52/60). start && key_len==11 -> stay IDLE, pulse err.
- LOAD (1 cycle): write w[0..NK-1] from key; i=NK, j=0 (i mod NK), rcon=01 -> EXPAND.
- EXPAND, per cycle: temp=w[i-1]; if j==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon=xtime(rcon) (xtime: shift left, ^1b if msb set); else if NK==8 && j==4: temp=SubWord(temp). w[i]=w[i-NK]^temp; i++, j=(j==NK-1)?0:j+1. Write of w[W-1] -> DONE.
- Modulo via wrapping counter j; no divider.
- DONE: ready=1; start (legal key_len) -> LOAD, ready drops the next cycle; start with illegal key_len -> err pulse, stay DONE, keys retained.
- start during LOAD/EXPAND ignored (no err).
- Reads: rk_req sampled only in DONE. rk_idx<=nr -> rk_data=round key, rk_valid=1 next cycle. rk_idx>nr -> rk_data=0, rk_valid=1, err=1 next cycle. rk_req outside DONE ignored, rk_valid=0.
- Reset values: busy=0, ready=0, nr=0, err=0, rk_valid=0, rk_data=0, state IDLE. Key storage not cleared. rst mid-expansion aborts; ready stays 0 until a new full expansion.

## Timing
- start sampled at edge E0; key words written E1; w[NK+k] written E2+k; ready=1 after E0+W-NK+1: 41 (128), 47 (192), 53 (256) cycles.
- busy high from E0+1 until the edge ready rises; busy and ready never both 1.
- Read latency 1 cycle, fully pipelined: back-to-back rk_req each cycle gives back-to-back rk_valid.
- err always a single-cycle pulse, registered.

## Structure
- aes_pkg: key_len enum, nk_of/nr_of/nw_of functions, xtime function, round-key width constant.
- Sub-module aes_sbox (combinational byte S-box); 4 instances form SubWord. Same module reused by the round engine.
- Storage: 15x128 register array written one 32-bit lane per cycle; 8-word sliding window supplies w[i-1] and w[i-NK].

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> ready after 41 cycles; rk 0 = key, rk 1 = a0fafe1788542cb123a339392a6c7605, rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, nr=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> ready after 47 cycles; rk 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready after 53 cycles; rk 14 = fe4890d1e6188d0b046df344706c631e (exercises NK==8, j==4 SubWord path).
- start with key_len=11 in IDLE -> one-cycle err, busy stays 0. rk_idx=11 with nr=10 -> rk_valid=1, rk_data=0, err=1.
- rst asserted mid-EXPAND (cycle 20) -> next cycle busy=0, ready=0; rk_req ignored; restart with the 128 key gives correct rk 10.
- start pulsed during EXPAND -> ignored, completion timing unchanged. Back-to-back reads idx 0..10 -> 11 consecutive rk_valid cycles with correct data.
